// File: rtl/pattern_scheduler_if.sv
// pattern_scheduler_if: control, ROM and chain-side signals of the beat-rate
// pattern scheduler, bundled so the scheduler and its environment connect
// through one port.
//   master : the environment (drives START/PAUSE/ABORT and ROM_DATA,
//            observes everything the scheduler produces)
//   slave  : the scheduler itself
// Signals:
//   START     1       one-cycle start pulse
//   PAUSE     1       level, freezes the beat divider
//   ABORT     1       one-cycle pulse, return to idle
//   ROM_DATA  4       registered beatmap ROM data
//   ROM_ADDR  ADDR_W  beatmap ROM address
//   PAT       4       pattern presented to the register chain
//   SHIFT     1       chain load strobe
//   BEAT      1       beat tick pulse
//   BUSY      1       song in progress
//   DONE      1       flush finished
//   BEAT_IDX  ADDR_W  index of last pattern shifted
interface pattern_scheduler_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              START;
  logic              PAUSE;
  logic              ABORT;
  logic [3:0]        ROM_DATA;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [3:0]        PAT;
  logic              SHIFT;
  logic              BEAT;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-1:0] BEAT_IDX;

  modport master (
    output START, PAUSE, ABORT, ROM_DATA,
    input  ROM_ADDR, PAT, SHIFT, BEAT, BUSY, DONE, BEAT_IDX
  );

  modport slave (
    input  START, PAUSE, ABORT, ROM_DATA,
    output ROM_ADDR, PAT, SHIFT, BEAT, BUSY, DONE, BEAT_IDX
  );
endinterface

// File: rtl/pattern_scheduler.sv
// pattern_scheduler: beat-rate sequencer for the falling-note lane chain.
// Every BEAT_DIV unpaused cycles it fetches one 4-bit lane pattern from the
// registered beatmap ROM and loads it into the pattern register chain with a
// one-cycle SHIFT strobe, two cycles after the BEAT pulse. After the last
// pattern it pushes DEPTH empty patterns to flush the chain, then raises DONE.
// Ports:
//   C       clock, rising edge
//   INIT_N  asynchronous active-low reset
//   bus     pattern_scheduler_if.slave (START/PAUSE/ABORT/ROM_DATA in,
//           ROM_ADDR/PAT/SHIFT/BEAT/BUSY/DONE/BEAT_IDX out)
// Build option:
//   PATTERN_SCHED_LOOP_EN  when defined the song wraps back to pattern 0
//                          forever; no flush, DONE never rises.
module pattern_scheduler #(
  parameter int unsigned BEAT_DIV = 12_500_000,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SONG_LEN = 200,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                C,
  input  logic                INIT_N,
  pattern_scheduler_if.slave  bus
);

  localparam int unsigned DIV_W = $clog2(BEAT_DIV);
  localparam int unsigned FL_W  = $clog2(DEPTH + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]        state;
  logic [DIV_W-1:0]  div;
  logic [ADDR_W-1:0] addr;
  logic [FL_W-1:0]   flush;
  logic              pend;
  logic [3:0]        pat;
  logic              shift;
  logic              beat;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] idx;
  logic              beat_tick;
  logic              start_ok;

  // beat_tick is the wrap cycle of the divider; BEAT is its registered copy,
  // so FETCH coincides with BEAT and LOAD follows, giving SHIFT at BEAT+2.
  assign beat_tick = busy && !bus.PAUSE && (div == DIV_LAST);
  assign start_ok  = bus.START && ((state == S_IDLE) || (state == S_FIN));

  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) begin
      div  <= '0;
      beat <= 1'b0;
    end else if (bus.ABORT || start_ok) begin
      div  <= '0;
      beat <= 1'b0;
    end else begin
      beat <= beat_tick;
      if (busy && !bus.PAUSE) begin
        div <= beat_tick ? '0 : div + 1'b1;
      end
    end
  end

  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) begin
      state <= S_IDLE;
      addr  <= '0;
      flush <= '0;
      pend  <= 1'b0;
      pat   <= '0;
      shift <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
    end else if (bus.ABORT) begin
      state <= S_IDLE;
      addr  <= '0;
      flush <= '0;
      pend  <= 1'b0;
      pat   <= '0;
      shift <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      shift <= 1'b0;
      pend  <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          if (bus.START) begin
            addr  <= '0;
            flush <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (beat_tick) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          pat   <= bus.ROM_DATA;
          shift <= 1'b1;
          idx   <= addr;
          if (addr == ADDR_LAST) begin
`ifdef PATTERN_SCHED_LOOP_EN
            addr  <= '0;
            state <= S_COUNT;
`else
            flush <= '0;
            state <= S_DRAIN;
`endif
          end else begin
            addr  <= addr + 1'b1;
            state <= S_COUNT;
          end
        end
        S_DRAIN: begin
          // Flush shifts mirror the FETCH/LOAD timing: BEAT -> pend -> SHIFT.
          pend <= beat;
          if (pend) begin
            pat   <= '0;
            shift <= 1'b1;
            flush <= flush + 1'b1;
          end else if (flush == FL_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ROM_ADDR = addr;
  assign bus.PAT      = pat;
  assign bus.SHIFT    = shift;
  assign bus.BEAT     = beat;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.BEAT_IDX = idx;

endmodule

// File: tb/tb_pattern_scheduler.sv
module tb_pattern_scheduler;
  localparam int unsigned BEAT_DIV = 4;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned SONG_LEN = 3;
  localparam int unsigned DEPTH    = 2;

  logic C = 1'b0;
  logic INIT_N = 1'b0;

  pattern_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  pattern_scheduler #(
    .BEAT_DIV(BEAT_DIV),
    .ADDR_W  (ADDR_W),
    .SONG_LEN(SONG_LEN),
    .DEPTH   (DEPTH)
  ) dut (
    .C     (C),
    .INIT_N(INIT_N),
    .bus   (bus)
  );

  always #5 C = ~C;

  // Registered beatmap ROM
  logic [3:0] rom [0:15];
  always @(posedge C) bus.ROM_DATA <= rom[bus.ROM_ADDR];

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int                due;
    logic [3:0]        pat;
    logic [ADDR_W-1:0] idx;
  } shift_t;

  shift_t exp_shift[$];
  int     exp_beat[$];

  // Reference model: counts unpaused busy cycles since START; every BEAT_DIV
  // of them is a beat k, whose chain load lands two cycles later carrying
  // pattern k (or an empty flush pattern past the end of the song).
  int cyc = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int cnt = 0;
  int k = 0;
  int finish_at = -1;

  always @(posedge C or negedge INIT_N) begin
    if (!INIT_N) begin
      m_busy = 1'b0; m_done = 1'b0; cnt = 0; k = 0; finish_at = -1;
      exp_shift.delete(); exp_beat.delete();
    end else begin
      cyc++;
      if (bus.ABORT) begin
        m_busy = 1'b0; m_done = 1'b0; finish_at = -1;
        exp_shift.delete(); exp_beat.delete();
      end else if (bus.START && !m_busy) begin
        m_busy = 1'b1; m_done = 1'b0; cnt = 0; k = 0; finish_at = -1;
      end else if (m_busy && !bus.PAUSE) begin
        cnt++;
        if (cnt % BEAT_DIV == 0) begin
          shift_t s;
          k++;
          exp_beat.push_back(cyc);
          s.due = cyc + 2;
`ifdef PATTERN_SCHED_LOOP_EN
          s.pat = rom[(k - 1) % SONG_LEN];
          s.idx = ADDR_W'((k - 1) % SONG_LEN);
`else
          if (k <= SONG_LEN) begin
            s.pat = rom[k - 1];
            s.idx = ADDR_W'(k - 1);
          end else begin
            s.pat = 4'h0;
            s.idx = ADDR_W'(SONG_LEN - 1);
          end
          if (k == SONG_LEN + DEPTH) finish_at = cyc + 3;
`endif
          exp_shift.push_back(s);
        end
      end
      if (m_busy && cyc == finish_at) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents BEAT or SHIFT
  always @(negedge C) begin
    if (bus.BEAT) begin
      if (exp_beat.size() == 0) check("beat_unexpected", bus.BEAT, 0);
      else begin
        int b;
        b = exp_beat.pop_front();
        check("beat_cycle", cyc, b);
      end
    end else if (exp_beat.size() != 0 && exp_beat[0] <= cyc) begin
      check("beat_missing", bus.BEAT, 1);
      void'(exp_beat.pop_front());
    end

    if (bus.SHIFT) begin
      if (exp_shift.size() == 0) check("shift_unexpected", bus.SHIFT, 0);
      else begin
        shift_t s;
        s = exp_shift.pop_front();
        check("shift_cycle", cyc, s.due);
        check("shift_pat", bus.PAT, s.pat);
        check("shift_idx", bus.BEAT_IDX, s.idx);
      end
    end else if (exp_shift.size() != 0 && exp_shift[0].due <= cyc) begin
      check("shift_missing", bus.SHIFT, 1);
      void'(exp_shift.pop_front());
    end

    check("busy", bus.BUSY, m_busy);
    check("done", bus.DONE, m_done);
    check("rom_addr_range", bus.ROM_ADDR < SONG_LEN, 1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge C);
  endtask

  task automatic pulse_start();
    bus.START = 1'b1;
    @(negedge C);
    bus.START = 1'b0;
  endtask

  task automatic wait_beat();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge C);
      if (bus.BEAT) seen = 1'b1;
    end
    if (!seen) check("wait_beat_timeout", bus.BEAT, 1);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.PAUSE = 1'b0;
    bus.ABORT = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 4'h0;
    rom[0] = 4'b0001; rom[1] = 4'b0110; rom[2] = 4'b1001;

    // Reset state
    tick(3);
    check("rst_pat", bus.PAT, 0);
    check("rst_shift", bus.SHIFT, 0);
    check("rst_beat", bus.BEAT, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_rom_addr", bus.ROM_ADDR, 0);
    check("rst_beat_idx", bus.BEAT_IDX, 0);
    INIT_N = 1'b1;
    tick(2);

    // Full song with flush
    pulse_start();
    tick(30);

    // Pause held 10 cycles during COUNT
    pulse_start();
    tick(1);
    bus.PAUSE = 1'b1;
    tick(10);
    bus.PAUSE = 1'b0;
    tick(40);

    // Abort on the second beat, then replay
    pulse_start();
    wait_beat();
    wait_beat();
    bus.ABORT = 1'b1;
    @(negedge C);
    bus.ABORT = 1'b0;
    check("abort_pat", bus.PAT, 0);
    check("abort_rom_addr", bus.ROM_ADDR, 0);
    check("abort_busy", bus.BUSY, 0);
    check("abort_shift", bus.SHIFT, 0);
    tick(12);
    pulse_start();
    tick(30);

    // Reset asserted during the LOAD cycle
    pulse_start();
    wait_beat();
    @(posedge C);
    #2 INIT_N = 1'b0;
    #1;
    check("init_pat", bus.PAT, 0);
    check("init_shift", bus.SHIFT, 0);
    check("init_busy", bus.BUSY, 0);
    check("init_rom_addr", bus.ROM_ADDR, 0);
    check("init_beat", bus.BEAT, 0);
    @(negedge C);
    @(negedge C);
    INIT_N = 1'b1;
    tick(10);

    // Randomized play with pauses, stray starts and aborts
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < SONG_LEN; i++) rom[i] = 4'($urandom_range(0, 15));
      repeat (80) begin
        @(negedge C);
        bus.PAUSE = ($urandom % 4) == 0;
        bus.START = ($urandom % 12) == 0;
        bus.ABORT = ($urandom % 70) == 0;
      end
      @(negedge C);
      bus.PAUSE = 1'b0;
      bus.START = 1'b0;
      bus.ABORT = 1'b1;
      @(negedge C);
      bus.ABORT = 1'b0;
      tick(3);
    end

    tick(5);
    check("scoreboard_drained", exp_shift.size() + exp_beat.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
